// File: rtl/light_pkg.sv
// -----------------------------------------------------------------------------
// light_pkg
// Shared light-code definitions for the intersection controller and its
// sequence monitor.
//
// Encoding (2 bits per direction):
//   LIGHT_R   = 2'b00  red
//   LIGHT_Y   = 2'b01  yellow
//   LIGHT_G   = 2'b10  green
//   LIGHT_ILL = 2'b11  never driven by a healthy controller
//
// Helper functions:
//   light_valid(code)        - code is one of R/Y/G
//   light_active(code)       - code is valid and not red (traffic may move)
//   light_legal_step(fr, to) - fr -> to is an allowed transition
// -----------------------------------------------------------------------------
package light_pkg;

    typedef enum logic [1:0] {
        LIGHT_R   = 2'b00,
        LIGHT_Y   = 2'b01,
        LIGHT_G   = 2'b10,
        LIGHT_ILL = 2'b11
    } light_code_t;

    localparam int LIGHT_CODE_W = 2;

    function automatic logic light_valid(input logic [1:0] code);
        return code != LIGHT_ILL;
    endfunction

    function automatic logic light_active(input logic [1:0] code);
        return (code == LIGHT_Y) || (code == LIGHT_G);
    endfunction

    // The only forward moves are G->Y->R->G; holding a code is always fine.
    function automatic logic light_legal_step(input logic [1:0] fr,
                                              input logic [1:0] to);
        logic ok;
        ok = (fr == to)
           || ((fr == LIGHT_G) && (to == LIGHT_Y))
           || ((fr == LIGHT_Y) && (to == LIGHT_R))
           || ((fr == LIGHT_R) && (to == LIGHT_G));
        return ok;
    endfunction

endpackage

// File: rtl/light_dir_checker.sv
// -----------------------------------------------------------------------------
// light_dir_checker
// Tracks one direction's light: the last valid code seen and how many
// consecutive samples that code has been held (saturating). Flags single-cycle
// error events for the current sample; the top module makes them sticky.
//
// Parameters:
//   MIN_YELLOW - shortest legal yellow run, in samples
//   CNT_W      - dwell counter width
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low reset
//   code       in   [1:0] sampled light code
//   dwell      out  [CNT_W-1:0] consecutive samples of the current code
//   prev_code  out  [1:0] last valid code (the tracking state, for observation)
//   seq_evt    out  current sample is an illegal valid-to-valid change
//   code_evt   out  current sample is the illegal code 11
//   yshort_evt out  current sample ends a yellow run that was too short
// -----------------------------------------------------------------------------
module light_dir_checker
    import light_pkg::*;
#(
    parameter int MIN_YELLOW = 3,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       code,
    output logic [CNT_W-1:0] dwell,
    output logic [1:0]       prev_code,
    output logic             seq_evt,
    output logic             code_evt,
    output logic             yshort_evt
);

    localparam logic [CNT_W-1:0] DWELL_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_Y     = CNT_W'(MIN_YELLOW);

    logic [1:0]       prev_q;
    logic [CNT_W-1:0] dwell_q;
    logic             valid;
    logic             same;
    logic             legal;

    assign valid = light_valid(code);
    assign same  = (code == prev_q);
    assign legal = light_legal_step(prev_q, code);

    // An 11 sample is reported only as a code error; it is neither a sequence
    // step nor the end of a yellow run, and it leaves the tracking state alone.
    always_comb begin
        seq_evt    = 1'b0;
        code_evt   = 1'b0;
        yshort_evt = 1'b0;
        if (!valid) begin
            code_evt = 1'b1;
        end else begin
            seq_evt    = !legal;
            yshort_evt = (prev_q == LIGHT_Y) && (code == LIGHT_R) && (dwell_q < MIN_Y);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q  <= LIGHT_R;
            dwell_q <= '0;
        end else if (valid) begin
            if (same) begin
                if (!(&dwell_q)) begin
                    dwell_q <= dwell_q + DWELL_ONE;
                end
            end else begin
                // Legal and illegal changes alike restart the run on the new code.
                prev_q  <= code;
                dwell_q <= DWELL_ONE;
            end
        end
    end

    assign dwell     = dwell_q;
    assign prev_code = prev_q;

endmodule

// File: rtl/light_seq_monitor.sv
// -----------------------------------------------------------------------------
// light_seq_monitor
// Passive checker for a two-direction traffic light controller. Each sample
// both directions are checked for illegal codes, illegal sequence steps and
// short yellows, and together for conflicting non-red lights. Every error
// class has a sticky flag that rises one cycle after the offending sample.
//
// Configuration macro: LIGHT_MON_STATS_EN
//   defined   - viol_cnt counts cycles holding at least one new error event
//               (saturating at 255, cleared by clr)
//   undefined - viol_cnt is tied to 0 and no counter is built
//
// Parameters:
//   MIN_YELLOW - shortest legal yellow run, in samples (default 3)
//   CNT_W      - dwell counter width (default 8)
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-low reset
//   sa, sb       in   [1:0] direction A / B light codes
//   clr          in   synchronous clear of sticky flags and viol_cnt
//   err_conflict out  sticky: both directions non-red in one sample
//   err_seq      out  sticky: illegal transition on either direction
//   err_code     out  sticky: code 11 seen on either direction
//   err_yshort   out  sticky: yellow shorter than MIN_YELLOW
//   err_any      out  OR of the four sticky flags
//   dwell_a/b    out  [CNT_W-1:0] samples of current code per direction
//   viol_cnt     out  [7:0] cycles with at least one new error event
// -----------------------------------------------------------------------------
module light_seq_monitor
    import light_pkg::*;
#(
    parameter int MIN_YELLOW = 3,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       sa,
    input  logic [1:0]       sb,
    input  logic             clr,
    output logic             err_conflict,
    output logic             err_seq,
    output logic             err_code,
    output logic             err_yshort,
    output logic             err_any,
    output logic [CNT_W-1:0] dwell_a,
    output logic [CNT_W-1:0] dwell_b,
    output logic [7:0]       viol_cnt
);

    logic       seq_a, code_a, yshort_a;
    logic       seq_b, code_b, yshort_b;
    logic [1:0] prev_a, prev_b;
    logic       conflict_evt;
    logic       seq_evt, code_evt, yshort_evt;

    logic       conflict_q, seq_q, code_q, yshort_q;

    light_dir_checker #(
        .MIN_YELLOW (MIN_YELLOW),
        .CNT_W      (CNT_W)
    ) u_dir_a (
        .clk        (clk),
        .reset      (reset),
        .code       (sa),
        .dwell      (dwell_a),
        .prev_code  (prev_a),
        .seq_evt    (seq_a),
        .code_evt   (code_a),
        .yshort_evt (yshort_a)
    );

    light_dir_checker #(
        .MIN_YELLOW (MIN_YELLOW),
        .CNT_W      (CNT_W)
    ) u_dir_b (
        .clk        (clk),
        .reset      (reset),
        .code       (sb),
        .dwell      (dwell_b),
        .prev_code  (prev_b),
        .seq_evt    (seq_b),
        .code_evt   (code_b),
        .yshort_evt (yshort_b)
    );

    // light_active() is false for 11, so a glitched direction never conflicts.
    assign conflict_evt = light_active(sa) && light_active(sb);
    assign seq_evt      = seq_a    | seq_b;
    assign code_evt     = code_a   | code_b;
    assign yshort_evt   = yshort_a | yshort_b;

    // A new event wins over clr in the same cycle, so nothing is lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            conflict_q <= 1'b0;
            seq_q      <= 1'b0;
            code_q     <= 1'b0;
            yshort_q   <= 1'b0;
        end else begin
            conflict_q <= (conflict_q & ~clr) | conflict_evt;
            seq_q      <= (seq_q      & ~clr) | seq_evt;
            code_q     <= (code_q     & ~clr) | code_evt;
            yshort_q   <= (yshort_q   & ~clr) | yshort_evt;
        end
    end

    assign err_conflict = conflict_q;
    assign err_seq      = seq_q;
    assign err_code     = code_q;
    assign err_yshort   = yshort_q;
    assign err_any      = conflict_q | seq_q | code_q | yshort_q;

`ifdef LIGHT_MON_STATS_EN
    logic       any_evt;
    logic [7:0] viol_q;

    assign any_evt = conflict_evt | seq_evt | code_evt | yshort_evt;

    // One count per cycle no matter how many error classes fire together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            viol_q <= 8'd0;
        end else if (clr) begin
            viol_q <= any_evt ? 8'd1 : 8'd0;
        end else if (any_evt && (viol_q != 8'hFF)) begin
            viol_q <= viol_q + 8'd1;
        end
    end

    assign viol_cnt = viol_q;
`else
    assign viol_cnt = 8'd0;
`endif

    // The tracked previous codes are observable on the sub-module ports; the
    // top does not need them, but keeping them visible eases probing.
    logic prev_unused;
    assign prev_unused = ^{prev_a, prev_b};

endmodule
